// File: rtl/dmem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dmem_port_arbiter
//  Purpose  : Shares the single-port, synchronous-read data memory between the
//             CPU MEM stage and a debug/loader port. Produces the CPU stall,
//             bounds CPU starvation of the debug port with a grant streak
//             counter, and enforces a one-cycle gap after every read issue.
//  Options  : ARB_STATS_EN - adds saturating grant / conflict counters.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 64,
    parameter int MAX_CPU_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    // CPU MEM stage
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic              cpu_stall,
    // debug / loader port
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rvalid,
    // data memory
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]       stat_cpu_grants,
    output logic [31:0]       stat_dbg_grants,
    output logic [31:0]       stat_conflict_cycles
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CPU_RD = 2'd1,
        S_DBG_RD = 2'd2
    } state_t;

    localparam logic [3:0] c_streak_max = 4'(MAX_CPU_STREAK);

    state_t     r_state;
    logic [3:0] r_streak;
    logic       r_rst_d;       // high for the first cycle after reset: no grants

    logic       w_idle;
    logic       w_streak_full;
    logic       w_dbg_win;
    logic       w_cpu_win;

    // Grants are only issued from IDLE, and never in the cycle following reset.
    assign w_idle        = (r_state == S_IDLE) & ~r_rst_d;
    assign w_streak_full = (r_streak == c_streak_max);
    // CPU wins by default; debug wins when alone or when the CPU streak is used up.
    assign w_dbg_win     = w_idle & dbg_req & (~cpu_req | w_streak_full);
    assign w_cpu_win     = w_idle & cpu_req & ~w_dbg_win;

    assign dbg_gnt    = w_dbg_win;
    assign cpu_rvalid = (r_state == S_CPU_RD);
    assign dbg_rvalid = (r_state == S_DBG_RD);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

    // Memory request is steered straight from the current winner; idle bus is all-zero.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_cpu_win) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (w_dbg_win) begin
            mem_en    = 1'b1;
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    // Stall the CPU whenever its request cannot finish this cycle.
    always_comb begin
        cpu_stall = cpu_req;
        case (r_state)
            S_IDLE:   cpu_stall = cpu_req & (~w_cpu_win | ~cpu_we);
            S_CPU_RD: cpu_stall = 1'b0;
            default:  cpu_stall = cpu_req;
        endcase
    end

    // Arbiter FSM and CPU streak counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_streak <= 4'd0;
            r_rst_d  <= 1'b1;
        end else begin
            r_rst_d <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cpu_win && !cpu_we)
                        r_state <= S_CPU_RD;
                    else if (w_dbg_win && !dbg_we)
                        r_state <= S_DBG_RD;
                    // streak only moves on IDLE cycles
                    if (w_dbg_win || !dbg_req)
                        r_streak <= 4'd0;
                    else if (w_cpu_win && !w_streak_full)
                        r_streak <= r_streak + 4'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] r_stat_cpu;
    logic [31:0] r_stat_dbg;
    logic [31:0] r_stat_conf;

    // Saturating grant and conflict counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_cpu  <= '0;
            r_stat_dbg  <= '0;
            r_stat_conf <= '0;
        end else begin
            if (w_cpu_win && (r_stat_cpu != 32'hFFFF_FFFF))
                r_stat_cpu <= r_stat_cpu + 32'd1;
            if (w_dbg_win && (r_stat_dbg != 32'hFFFF_FFFF))
                r_stat_dbg <= r_stat_dbg + 32'd1;
            if ((r_state == S_IDLE) && cpu_req && dbg_req && (r_stat_conf != 32'hFFFF_FFFF))
                r_stat_conf <= r_stat_conf + 32'd1;
        end
    end

    assign stat_cpu_grants      = r_stat_cpu;
    assign stat_dbg_grants      = r_stat_dbg;
    assign stat_conflict_cycles = r_stat_conf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_port_arbiter
//  Purpose  : Self-checking bench for dmem_port_arbiter with a transaction-level
//             reference model and a behavioural synchronous-read memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 64;
    localparam int MAXS   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req, cpu_we, cpu_rvalid, cpu_stall;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
`ifdef ARB_STATS_EN
    logic [31:0]       stat_cpu_grants, stat_dbg_grants, stat_conflict_cycles;
`endif

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_CPU_STREAK(MAXS)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
        ,
        .stat_cpu_grants(stat_cpu_grants), .stat_dbg_grants(stat_dbg_grants),
        .stat_conflict_cycles(stat_conflict_cycles)
`endif
    );

    // Behavioural single-port memory with one-cycle read latency.
    logic [DATA_W-1:0] tb_mem [0:1023];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) tb_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr];
        end
    end

    // ---------------- reference model ----------------
    int                n_checks = 0;
    int                n_fail   = 0;
    logic [DATA_W-1:0] ref_mem [0:1023];
    int                m_pend;      // 0 none, 1 CPU read returning, 2 debug read returning
    bit                m_block;     // first cycle after reset: no service
    int                m_streak;
    logic [DATA_W-1:0] m_rd;
    bit                e_cpu_gnt, e_dbg_gnt;
    logic [207:0]      exp_v;
    logic [207:0]      obs_v;

    assign obs_v = {cpu_stall, dbg_gnt, mem_en, mem_we, cpu_rvalid, dbg_rvalid,
                    mem_addr, mem_wdata, cpu_rdata, dbg_rdata};

    function automatic logic [DATA_W-1:0] init_val(int a);
        return 64'hC0DE_0000_0000_0000 | 64'(a * 7 + 1);
    endfunction

    function automatic void model_expect();
        logic st, gd, en, we, cv, dv;
        logic [ADDR_W-1:0] ad;
        logic [DATA_W-1:0] wd, cr, dr;
        st = cpu_req; gd = 0; en = 0; we = 0; cv = 0; dv = 0;
        ad = '0; wd = '0; cr = '0; dr = '0;
        e_cpu_gnt = 0; e_dbg_gnt = 0;
        if (!m_block) begin
            if (m_pend == 1) begin
                cv = 1; cr = m_rd; st = 0;
            end else if (m_pend == 2) begin
                dv = 1; dr = m_rd;
            end else begin
                e_dbg_gnt = dbg_req && (!cpu_req || m_streak == MAXS);
                e_cpu_gnt = cpu_req && !e_dbg_gnt;
                if (e_cpu_gnt) begin
                    en = 1; we = cpu_we; ad = cpu_addr; wd = cpu_wdata; st = !cpu_we;
                end
                if (e_dbg_gnt) begin
                    gd = 1; en = 1; we = dbg_we; ad = dbg_addr; wd = dbg_wdata;
                end
            end
        end
        exp_v = {st, gd, en, we, cv, dv, ad, wd, cr, dr};
    endfunction

    function automatic void model_commit();
        if (e_cpu_gnt && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
        if (e_dbg_gnt && dbg_we) ref_mem[dbg_addr] = dbg_wdata;
        if (rst) begin
            m_pend = 0; m_streak = 0; m_block = 1;
            return;
        end
        if (m_block || m_pend != 0) begin
            if (m_block && !dbg_req) m_streak = 0;
            m_block = 0; m_pend = 0;
            return;
        end
        if (e_cpu_gnt && !cpu_we) begin m_rd = ref_mem[cpu_addr]; m_pend = 1; end
        if (e_dbg_gnt && !dbg_we) begin m_rd = ref_mem[dbg_addr]; m_pend = 2; end
        if (e_dbg_gnt || !dbg_req) m_streak = 0;
        else if (e_cpu_gnt && m_streak < MAXS) m_streak++;
    endfunction

    task automatic settle();
        #1;
        model_expect();
    endtask

    task automatic advance();
        model_commit();
        @(negedge clk);
    endtask

    task automatic rand_cpu();
        cpu_req = 1; cpu_we = 1'($urandom % 2); cpu_addr = 10'($urandom % 16);
        cpu_wdata = {$urandom, $urandom};
    endtask

    task automatic rand_dbg();
        dbg_req = 1; dbg_we = 1'($urandom % 2); dbg_addr = 10'($urandom % 16);
        dbg_wdata = {$urandom, $urandom};
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1;
        settle();
        n_checks++; if (obs_v !== exp_v) begin n_fail++; $display("FAIL reset_outputs: got %h required %h", obs_v, exp_v); end
        advance();
        rst = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 10'd7;
        settle();
        n_checks++; if ({cpu_stall, mem_en, cpu_rvalid, dbg_gnt} !== 4'b1000) begin
            n_fail++; $display("FAIL post_reset_block: got %b required 1000", {cpu_stall, mem_en, cpu_rvalid, dbg_gnt}); end
        advance();
        for (int i = 0; i < 2; i++) begin
            settle();
            n_checks++; if (obs_v !== exp_v) begin n_fail++; $display("FAIL reset_load_cycle%0d: got %h required %h", i, obs_v, exp_v); end
            advance();
            cpu_req = 0;
        end
    endtask

    task automatic test_cpu_store_load();
        cpu_req = 1; cpu_we = 1; cpu_addr = 10'd2; cpu_wdata = 64'd1;
        settle();
        n_checks++; if ({cpu_stall, mem_en, mem_we} !== 3'b011) begin
            n_fail++; $display("FAIL store_no_stall: got %b required 011", {cpu_stall, mem_en, mem_we}); end
        advance();
        cpu_we = 0;
        settle();
        n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL load_stall: got %b required 1", cpu_stall); end
        advance();
        cpu_req = 0;
        settle();
        n_checks++; if ({cpu_rvalid, cpu_stall, cpu_rdata} !== {2'b10, 64'd1}) begin
            n_fail++; $display("FAIL load_data: got rvalid=%b stall=%b data=%h required 1 0 1", cpu_rvalid, cpu_stall, cpu_rdata); end
        advance();
    endtask

    task automatic test_dbg_read();
        dbg_req = 1; dbg_we = 0; dbg_addr = 10'd5;
        settle();
        n_checks++; if ({dbg_gnt, mem_en, mem_addr} !== {2'b11, 10'd5}) begin
            n_fail++; $display("FAIL dbg_grant: got gnt=%b en=%b addr=%0d required 1 1 5", dbg_gnt, mem_en, mem_addr); end
        advance();
        dbg_req = 0;
        settle();
        n_checks++; if ({dbg_rvalid, mem_en, dbg_rdata} !== {2'b10, init_val(5)}) begin
            n_fail++; $display("FAIL dbg_rvalid: got rvalid=%b en=%b data=%h required 1 0 %h", dbg_rvalid, mem_en, dbg_rdata, init_val(5)); end
        advance();
    endtask

    task automatic test_contention();
        int  grants = 0;
        int  cyc    = 0;
        bit  gc, gd;
        rand_cpu(); rand_dbg();
        while (grants < 20 && cyc < 300) begin
            settle();
            n_checks++; if (obs_v !== exp_v) begin n_fail++; $display("FAIL contention_cycle%0d: got %h required %h", cyc, obs_v, exp_v); end
            if (mem_en === 1'b1) begin
                n_checks++; if (dbg_gnt !== (grants % 5 == 4)) begin
                    n_fail++; $display("FAIL grant_pattern%0d: got dbg_gnt=%b required %b", grants, dbg_gnt, (grants % 5 == 4)); end
                grants++;
            end
            gc = e_cpu_gnt; gd = e_dbg_gnt;
            advance();
            cyc++;
            if (gc) rand_cpu();
            if (gd) rand_dbg();
        end
        n_checks++; if (grants < 20) begin n_fail++; $display("FAIL contention_timeout: got %0d grants required 20", grants); end
        cpu_req = 0; dbg_req = 0;
    endtask

    task automatic test_simul_load_dbg_write();
        logic [DATA_W-1:0] x = 64'hFEED_BEEF_1234_5678;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_checks++; if (obs_v !== exp_v) begin n_fail++; $display("FAIL simul_idle%0d: got %h required %h", i, obs_v, exp_v); end
            advance();
        end
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'd9;
        dbg_req = 1; dbg_we = 1; dbg_addr = 10'd11; dbg_wdata = x;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_checks++; if (obs_v !== exp_v) begin n_fail++; $display("FAIL simul_cycle%0d: got %h required %h", i, obs_v, exp_v); end
            n_checks++; if (dbg_gnt !== (i == 2)) begin n_fail++; $display("FAIL simul_dbg_gnt%0d: got %b required %b", i, dbg_gnt, (i == 2)); end
            advance();
            cpu_req = 0;
        end
        dbg_we = 0;
        settle();
        advance();
        dbg_req = 0;
        settle();
        n_checks++; if ({dbg_rvalid, dbg_rdata} !== {1'b1, x}) begin
            n_fail++; $display("FAIL dbg_readback: got %b %h required 1 %h", dbg_rvalid, dbg_rdata, x); end
        advance();
    endtask

    task automatic test_reset_mid_read();
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'd600;
        settle();
        advance();
        rst = 1;
        settle();
        n_checks++; if (obs_v !== exp_v) begin n_fail++; $display("FAIL rst_in_cpu_rd: got %h required %h", obs_v, exp_v); end
        advance();
        rst = 0;
        settle();
        n_checks++; if ({cpu_rvalid, mem_en, cpu_stall, dbg_gnt} !== 4'b0010) begin
            n_fail++; $display("FAIL after_mid_reset: got %b required 0010", {cpu_rvalid, mem_en, cpu_stall, dbg_gnt}); end
        advance();
        settle();
        advance();
        cpu_req = 0;
        settle();
        n_checks++; if ({cpu_rvalid, cpu_rdata} !== {1'b1, init_val(600)}) begin
            n_fail++; $display("FAIL reissued_load: got %b %h required 1 %h", cpu_rvalid, cpu_rdata, init_val(600)); end
        advance();
    endtask

    task automatic test_random();
        bit gc, gd;
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom % 60 == 0);
            if (!cpu_req && ($urandom % 3 != 0)) rand_cpu();
            if (!dbg_req && ($urandom % 3 == 0)) rand_dbg();
            settle();
            n_checks++; if (obs_v !== exp_v) begin n_fail++; $display("FAIL random_cycle%0d: got %h required %h", c, obs_v, exp_v); end
            gc = e_cpu_gnt; gd = e_dbg_gnt;
            advance();
            if (gc) cpu_req = 0;
            if (gd) dbg_req = 0;
        end
        rst = 0; cpu_req = 0; dbg_req = 0;
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        int grants = 0;
        int cyc    = 0;
        int both   = 0;
        bit gc, gd;
        rst = 1;
        settle(); advance();
        rst = 0;
        settle(); advance();
        rand_cpu(); rand_dbg();
        while (grants < 10 && cyc < 200) begin
            settle();
            n_checks++; if (obs_v !== exp_v) begin n_fail++; $display("FAIL stats_cycle%0d: got %h required %h", cyc, obs_v, exp_v); end
            if (!m_block && m_pend == 0 && cpu_req && dbg_req) both++;
            gc = e_cpu_gnt; gd = e_dbg_gnt;
            if (gc || gd) grants++;
            advance();
            cyc++;
            if (grants < 10) begin
                if (gc) rand_cpu();
                if (gd) rand_dbg();
            end else begin
                cpu_req = 0; dbg_req = 0;
            end
        end
        settle(); advance();
        settle();
        n_checks++; if (stat_cpu_grants !== 32'd8) begin n_fail++; $display("FAIL stat_cpu: got %0d required 8", stat_cpu_grants); end
        n_checks++; if (stat_dbg_grants !== 32'd2) begin n_fail++; $display("FAIL stat_dbg: got %0d required 2", stat_dbg_grants); end
        n_checks++; if (stat_conflict_cycles !== 32'(both)) begin
            n_fail++; $display("FAIL stat_conflict: got %0d required %0d", stat_conflict_cycles, both); end
        advance();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        for (int a = 0; a < 1024; a++) begin
            tb_mem[a]  = init_val(a);
            ref_mem[a] = init_val(a);
        end
        m_pend = 0; m_block = 1; m_streak = 0; m_rd = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_cpu_store_load();
        test_dbg_read();
        test_contention();
        test_simul_load_dbg_write();
        test_reset_mid_read();
        test_random();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
